axis_to_memory_ctrl: RTL and testbench

- Parametrised AXI-Stream-to-BRAM packet writer. Successor of the fixed 32-bit heap stream writer.
- Adds configurable data/address width and software arming with a start address and beat limit.
- Adds real backpressure, overflow handling (drain or ring-wrap), and done/overflow/beat-count status.
- Sits between the DMA AXI-Stream output and a heap-memory BRAM write port.

---
 rtl/axis_to_memory_ctrl.sv | 150 +++++++++++++++
 tb/tb_axis_to_memory_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_to_memory_ctrl.sv
// AXI-Stream to BRAM packet writer: software-armed capture of one packet into
// heap memory with a beat limit, drain or ring-wrap overflow handling and status.
module axis_to_memory_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 11,
  parameter int COUNT_WIDTH = 16,
  parameter int WRAP_MODE   = 0
) (
  input  logic                     axis_clk,
  input  logic                     axis_reset,
  input  logic [DATA_WIDTH-1:0]    axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]  axis_tkeep,
  input  logic                     axis_tlast,
  input  logic                     axis_tvalid,
  output logic                     axis_tready,
  input  logic                     cfg_arm,
  input  logic [ADDR_WIDTH-1:0]    cfg_start_addr,
  input  logic [COUNT_WIDTH-1:0]   cfg_max_beats,
  output logic                     heap_mem_port_a_clk,
  output logic [ADDR_WIDTH-1:0]    heap_mem_port_a_addr,
  output logic [DATA_WIDTH-1:0]    heap_mem_port_a_wr_data,
  output logic [DATA_WIDTH/8-1:0]  heap_mem_port_a_wr_en,
  output logic                     status_busy,
  output logic                     status_done,
  output logic                     status_overflow,
  output logic [COUNT_WIDTH-1:0]   status_beat_count
);

  localparam int                      BPB       = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0]   BPB_ADDR  = ADDR_WIDTH'(BPB);
  localparam logic [COUNT_WIDTH-1:0]  COUNT_MAX = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                   state_r;
  logic [ADDR_WIDTH-1:0]    base_r;
  logic [COUNT_WIDTH-1:0]   limit_r;
  logic [ADDR_WIDTH-1:0]    next_addr_r;
  logic [COUNT_WIDTH-1:0]   beat_count_r;
  logic                     overflow_r;
  logic [ADDR_WIDTH-1:0]    addr_r;
  logic [DATA_WIDTH-1:0]    wr_data_r;
  logic [BPB-1:0]           wr_en_r;
  logic                     done_r;

  logic                     accept_s;
  logic [COUNT_WIDTH-1:0]   count_inc_s;
  logic                     limit_hit_s;
  logic [ADDR_WIDTH-1:0]    next_addr_inc_s;

  assign heap_mem_port_a_clk     = axis_clk;
  assign axis_tready             = (state_r != ST_IDLE);
  assign status_busy             = (state_r != ST_IDLE);
  assign heap_mem_port_a_addr    = addr_r;
  assign heap_mem_port_a_wr_data = wr_data_r;
  assign heap_mem_port_a_wr_en   = wr_en_r;
  assign status_done             = done_r;
  assign status_overflow         = overflow_r;
  assign status_beat_count       = beat_count_r;

  // Handshake, saturating beat increment, limit detection and address step.
  always_comb begin
    accept_s        = axis_tvalid & axis_tready;
    next_addr_inc_s = next_addr_r + BPB_ADDR;
    if (beat_count_r == COUNT_MAX) begin
      count_inc_s = beat_count_r;
    end else begin
      count_inc_s = beat_count_r + COUNT_WIDTH'(1);
    end
    limit_hit_s = (limit_r != '0) && (count_inc_s == limit_r);
  end

  // Capture FSM with registered BRAM write port and status outputs.
  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_r      <= ST_IDLE;
      base_r       <= '0;
      limit_r      <= '0;
      next_addr_r  <= '0;
      beat_count_r <= '0;
      overflow_r   <= 1'b0;
      addr_r       <= '0;
      wr_data_r    <= '0;
      wr_en_r      <= '0;
      done_r       <= 1'b0;
    end else begin
      wr_en_r <= '0;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A beat presented alongside the arm is not accepted: tready is still low.
          if (cfg_arm) begin
            base_r       <= cfg_start_addr;
            limit_r      <= cfg_max_beats;
            next_addr_r  <= cfg_start_addr;
            beat_count_r <= '0;
            overflow_r   <= 1'b0;
            state_r      <= ST_WRITE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          if (accept_s) begin
            addr_r       <= next_addr_r;
            wr_data_r    <= axis_tdata;
            wr_en_r      <= axis_tkeep;
            beat_count_r <= count_inc_s;
            if (axis_tlast) begin
              done_r      <= 1'b1;
              next_addr_r <= next_addr_inc_s;
              state_r     <= ST_IDLE;
            end else if (limit_hit_s) begin
              overflow_r <= 1'b1;
              if (WRAP_MODE != 0) begin
                next_addr_r <= base_r;
                state_r     <= ST_WRITE;
              end else begin
                next_addr_r <= next_addr_inc_s;
                state_r     <= ST_DRAIN;
              end
            end else begin
              next_addr_r <= next_addr_inc_s;
              state_r     <= ST_WRITE;
            end
          end else begin
            state_r <= ST_WRITE;
          end
        end
        ST_DRAIN: begin
          // Remaining beats are swallowed so the source can finish its packet.
          if (accept_s && axis_tlast) begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_memory_ctrl.sv
// Bench for axis_to_memory_ctrl: drain and ring-wrap instances share stimulus and
// are checked every cycle against a packet-level reference model.
module tb_axis_to_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tvalid;
  logic        cfg_arm;
  logic [10:0] cfg_start;
  logic [15:0] cfg_max;

  logic        d_tready [2];
  logic        d_mclk   [2];
  logic [10:0] d_addr   [2];
  logic [31:0] d_data   [2];
  logic [3:0]  d_wen    [2];
  logic        d_busy   [2];
  logic        d_done   [2];
  logic        d_ovf    [2];
  logic [15:0] d_cnt    [2];

  int n_cmp = 0;
  int n_err = 0;

  // reference model state, index = WRAP_MODE of the instance
  bit          m_busy [2];
  bit          m_drop [2];
  bit          m_ovf  [2];
  int          m_base [2];
  int          m_limit[2];
  int          m_next [2];
  int          m_cnt  [2];
  logic [10:0] e_addr [2];
  logic [31:0] e_data [2];
  logic [3:0]  e_wen  [2];
  logic        e_done [2];

  int la0[$];
  int ld0[$];
  int ln0[$];
  int la1[$];

  always #5 clk = ~clk;

  axis_to_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .COUNT_WIDTH(16), .WRAP_MODE(0)) dut0 (
    .axis_clk(clk), .axis_reset(reset), .axis_tdata(tdata), .axis_tkeep(tkeep),
    .axis_tlast(tlast), .axis_tvalid(tvalid), .axis_tready(d_tready[0]),
    .cfg_arm(cfg_arm), .cfg_start_addr(cfg_start), .cfg_max_beats(cfg_max),
    .heap_mem_port_a_clk(d_mclk[0]), .heap_mem_port_a_addr(d_addr[0]),
    .heap_mem_port_a_wr_data(d_data[0]), .heap_mem_port_a_wr_en(d_wen[0]),
    .status_busy(d_busy[0]), .status_done(d_done[0]),
    .status_overflow(d_ovf[0]), .status_beat_count(d_cnt[0])
  );

  axis_to_memory_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .COUNT_WIDTH(16), .WRAP_MODE(1)) dut1 (
    .axis_clk(clk), .axis_reset(reset), .axis_tdata(tdata), .axis_tkeep(tkeep),
    .axis_tlast(tlast), .axis_tvalid(tvalid), .axis_tready(d_tready[1]),
    .cfg_arm(cfg_arm), .cfg_start_addr(cfg_start), .cfg_max_beats(cfg_max),
    .heap_mem_port_a_clk(d_mclk[1]), .heap_mem_port_a_addr(d_addr[1]),
    .heap_mem_port_a_wr_data(d_data[1]), .heap_mem_port_a_wr_en(d_wen[1]),
    .status_busy(d_busy[1]), .status_done(d_done[1]),
    .status_overflow(d_ovf[1]), .status_beat_count(d_cnt[1])
  );

  task automatic check(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d got=%h exp=%h t=%0t", nm, m, got, exp, $time);
    end
  endtask

  // Packet-level rules applied to the inputs seen at the clock edge.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      e_wen[m]  = 4'h0;
      e_done[m] = 1'b0;
      if (reset) begin
        m_busy[m] = 1'b0; m_drop[m] = 1'b0; m_ovf[m] = 1'b0;
        m_base[m] = 0; m_limit[m] = 0; m_next[m] = 0; m_cnt[m] = 0;
        e_addr[m] = 11'h0; e_data[m] = 32'h0;
      end else if (!m_busy[m]) begin
        if (cfg_arm) begin
          m_busy[m] = 1'b1; m_drop[m] = 1'b0; m_ovf[m] = 1'b0;
          m_base[m] = int'(cfg_start); m_limit[m] = int'(cfg_max);
          m_next[m] = int'(cfg_start); m_cnt[m] = 0;
        end
      end else if (tvalid) begin
        if (m_drop[m]) begin
          if (tlast) begin
            m_busy[m] = 1'b0; m_drop[m] = 1'b0; e_done[m] = 1'b1;
          end
        end else begin
          e_addr[m] = 11'(m_next[m]);
          e_data[m] = tdata;
          e_wen[m]  = tkeep;
          if (m_cnt[m] != 65535) m_cnt[m] = m_cnt[m] + 1;
          m_next[m] = (m_next[m] + 4) % 2048;
          if (tlast) begin
            m_busy[m] = 1'b0; e_done[m] = 1'b1;
          end else if (m_limit[m] != 0 && m_cnt[m] == m_limit[m]) begin
            m_ovf[m] = 1'b1;
            if (m == 1) m_next[m] = m_base[m];
            else        m_drop[m] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int m = 0; m < 2; m++) begin
      check("tready",     m, 32'(d_tready[m]), 32'(m_busy[m]));
      check("busy",       m, 32'(d_busy[m]),   32'(m_busy[m]));
      check("wr_en",      m, 32'(d_wen[m]),    32'(e_wen[m]));
      check("addr",       m, 32'(d_addr[m]),   32'(e_addr[m]));
      check("wr_data",    m, d_data[m],        e_data[m]);
      check("done",       m, 32'(d_done[m]),   32'(e_done[m]));
      check("overflow",   m, 32'(d_ovf[m]),    32'(m_ovf[m]));
      check("beat_count", m, 32'(d_cnt[m]),    32'(m_cnt[m]));
      check("mem_clk",    m, 32'(d_mclk[m]),   32'(clk));
    end
  endtask

  // One clock: sample 1 time unit after the edge, update model, compare, log writes.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
    if (d_wen[0] != 4'h0) begin
      la0.push_back(int'(d_addr[0])); ld0.push_back(int'(d_data[0])); ln0.push_back(int'(d_done[0]));
    end
    if (d_wen[1] != 4'h0) la1.push_back(int'(d_addr[1]));
  endtask

  task automatic clear_logs();
    la0.delete(); ld0.delete(); ln0.delete(); la1.delete();
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic arm_cfg(input logic [10:0] a, input logic [15:0] mx);
    cfg_arm = 1'b1; cfg_start = a; cfg_max = mx;
    tick();
    cfg_arm = 1'b0;
  endtask

  task automatic sendk(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    int n;
    n = 0;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    do begin
      acc = d_tready[0];
      tick();
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout got=no_accept exp=accept_within_20 t=%0t", $time);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    sendk(d, 4'hF, l);
  endtask

  initial begin
    reset = 1'b1; tdata = 32'h0; tkeep = 4'h0; tlast = 1'b0; tvalid = 1'b0;
    cfg_arm = 1'b0; cfg_start = 11'h0; cfg_max = 16'h0;
    repeat (3) tick();
    check("rst_wr_en", 0, 32'(d_wen[0]), 32'h0);
    check("rst_tready", 0, 32'(d_tready[0]), 32'h0);
    reset = 1'b0;
    idle(2);

    // basic 4-beat packet
    clear_logs();
    arm_cfg(11'h100, 16'd0);
    for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), i == 3);
    idle(2);
    check("t1_nwrites", 0, 32'(la0.size()), 32'd4);
    if (la0.size() == 4) begin
      check("t1_addr0", 0, 32'(la0[0]), 32'h100);
      check("t1_addr3", 0, 32'(la0[3]), 32'h10C);
      check("t1_data3", 0, 32'(ld0[3]), 32'hA3);
      check("t1_done_last", 0, 32'(ln0[3]), 32'h1);
      check("t1_done_first", 0, 32'(ln0[0]), 32'h0);
    end
    check("t1_count", 0, 32'(d_cnt[0]), 32'd4);
    check("t1_ovf", 0, 32'(d_ovf[0]), 32'h0);
    check("t1_tready", 0, 32'(d_tready[0]), 32'h0);

    // source gap in the middle of a packet
    clear_logs();
    arm_cfg(11'h200, 16'd0);
    send(32'hB0, 1'b0);
    idle(1);
    send(32'hB1, 1'b0);
    send(32'hB2, 1'b1);
    idle(2);
    check("t2_nwrites", 0, 32'(la0.size()), 32'd3);
    if (la0.size() == 3) check("t2_addr2", 0, 32'(la0[2]), 32'h208);

    // limit 2, 5-beat packet
    clear_logs();
    arm_cfg(11'h040, 16'd2);
    for (int i = 0; i < 5; i++) send(32'hC0 + 32'(i), i == 4);
    idle(2);
    check("t3_nwrites", 0, 32'(la0.size()), 32'd2);
    if (la0.size() == 2) check("t3_addr1", 0, 32'(la0[1]), 32'h044);
    check("t3_ovf", 0, 32'(d_ovf[0]), 32'h1);
    check("t3_count", 0, 32'(d_cnt[0]), 32'd2);
    check("t3_wrap_nwrites", 1, 32'(la1.size()), 32'd5);

    // limit 2, 3-beat packet in ring mode
    clear_logs();
    arm_cfg(11'h040, 16'd2);
    for (int i = 0; i < 3; i++) send(32'hD0 + 32'(i), i == 2);
    idle(2);
    check("t4_nwrites", 1, 32'(la1.size()), 32'd3);
    if (la1.size() == 3) begin
      check("t4_addr1", 1, 32'(la1[1]), 32'h044);
      check("t4_addr2", 1, 32'(la1[2]), 32'h040);
    end
    check("t4_ovf", 1, 32'(d_ovf[1]), 32'h1);
    check("t4_count", 1, 32'(d_cnt[1]), 32'd3);

    // tvalid before arm, arm with tvalid, arm mid-packet
    clear_logs();
    tvalid = 1'b1; tdata = 32'hE0; tkeep = 4'hF; tlast = 1'b0;
    repeat (3) tick();
    check("t5_no_write", 0, 32'(la0.size()), 32'd0);
    cfg_arm = 1'b1; cfg_start = 11'h020; cfg_max = 16'd0;
    tick();
    cfg_arm = 1'b0;
    check("t5_no_accept_on_arm", 0, 32'(la0.size()), 32'd0);
    send(32'hE0, 1'b0);
    cfg_arm = 1'b1; cfg_start = 11'h300; cfg_max = 16'd1;
    send(32'hE1, 1'b0);
    cfg_arm = 1'b0;
    send(32'hE2, 1'b1);
    idle(2);
    check("t5_nwrites", 0, 32'(la0.size()), 32'd3);
    if (la0.size() == 3) begin
      check("t5_addr0", 0, 32'(la0[0]), 32'h020);
      check("t5_data0", 0, 32'(ld0[0]), 32'hE0);
      check("t5_addr2", 0, 32'(la0[2]), 32'h028);
    end
    check("t5_count", 0, 32'(d_cnt[0]), 32'd3);

    // reset mid-packet, then a clean packet
    clear_logs();
    arm_cfg(11'h080, 16'd0);
    send(32'hF0, 1'b0);
    send(32'hF1, 1'b0);
    reset = 1'b1; tvalid = 1'b1; tdata = 32'hF2; tlast = 1'b0;
    tick();
    check("t6_rst_wr_en", 0, 32'(d_wen[0]), 32'h0);
    check("t6_rst_done", 0, 32'(d_done[0]), 32'h0);
    reset = 1'b0;
    idle(1);
    clear_logs();
    arm_cfg(11'h080, 16'd0);
    send(32'h11, 1'b0);
    send(32'h12, 1'b1);
    idle(1);
    check("t6_count", 0, 32'(d_cnt[0]), 32'd2);
    check("t6_nwrites", 0, 32'(la0.size()), 32'd2);

    // randomized packets
    for (int p = 0; p < 40; p++) begin
      int len;
      idle($urandom_range(0, 2));
      arm_cfg(11'($urandom), 16'($urandom_range(0, 5)));
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        if ($urandom_range(0, 7) == 0) begin
          cfg_arm = 1'b1; cfg_start = 11'($urandom); cfg_max = 16'($urandom_range(0, 5));
        end
        sendk($urandom, 4'($urandom_range(1, 15)), b == len - 1);
        cfg_arm = 1'b0;
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
